// File: rtl/env_adsr.sv
// Per-voice ADSR envelope: a 16-bit accumulator stepped once per sample strobe,
// plus a two-stage multiplier that scales the offset-binary voice sample by it.
module env_adsr #(
  parameter int WAVE_W = 12,
  parameter int ACC_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_en,
  input  logic              gate,
  input  logic [7:0]        attack_rate,
  input  logic [7:0]        decay_rate,
  input  logic [7:0]        sustain_lvl,
  input  logic [7:0]        release_rate,
  input  logic [WAVE_W-1:0] wave_in,
  output logic [WAVE_W-1:0] wave_out,
  output logic              out_valid,
  output logic [WAVE_W-1:0] env_level,
  output logic [2:0]        state,
  output logic              busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ATTACK  = 3'd1,
    DECAY   = 3'd2,
    SUSTAIN = 3'd3,
    RELEASE = 3'd4
  } adsr_state_t;

  localparam logic [ACC_W-1:0]  ACC_MAX = {ACC_W{1'b1}};
  localparam logic [WAVE_W-1:0] MID     = {1'b1, {(WAVE_W-1){1'b0}}};

  adsr_state_t      state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] target;
  logic [ACC_W:0]   att_step, dec_step, rel_step;
  logic [ACC_W:0]   att_sum, dec_diff, rel_diff;

  // Steps are rate*16, kept one bit wider than acc so overflow/underflow is visible.
  assign att_step = {{(ACC_W-11){1'b0}}, attack_rate,  4'b0000};
  assign dec_step = {{(ACC_W-11){1'b0}}, decay_rate,   4'b0000};
  assign rel_step = {{(ACC_W-11){1'b0}}, release_rate, 4'b0000};
  assign att_sum  = {1'b0, acc_q} + att_step;
  assign dec_diff = {1'b0, acc_q} - dec_step;
  assign rel_diff = {1'b0, acc_q} - rel_step;
  assign target   = {sustain_lvl, sustain_lvl};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    if (sample_en) begin
      case (state_q)
        IDLE: begin
          if (gate) state_d = ATTACK;
        end
        ATTACK: begin
          if (!gate) begin
            state_d = RELEASE;
          end else if (attack_rate == 8'd0 || att_sum >= {1'b0, ACC_MAX}) begin
            acc_d   = ACC_MAX;
            state_d = DECAY;
          end else begin
            acc_d = att_sum[ACC_W-1:0];
          end
        end
        DECAY: begin
          // A borrow out of the subtract means the result went below zero.
          if (!gate) begin
            state_d = RELEASE;
          end else if (decay_rate == 8'd0 || dec_diff[ACC_W] ||
                       dec_diff[ACC_W-1:0] <= target) begin
            acc_d   = target;
            state_d = SUSTAIN;
          end else begin
            acc_d = dec_diff[ACC_W-1:0];
          end
        end
        SUSTAIN: begin
          if (!gate) state_d = RELEASE;
          else       acc_d   = target;
        end
        RELEASE: begin
          // Retrigger keeps the current level instead of restarting from zero.
          if (gate) begin
            state_d = ATTACK;
          end else if (release_rate == 8'd0 || rel_diff[ACC_W] ||
                       rel_diff[ACC_W-1:0] == '0) begin
            acc_d   = '0;
            state_d = IDLE;
          end else begin
            acc_d = rel_diff[ACC_W-1:0];
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
        end
      endcase
    end
  end

  assign env_level = acc_q[ACC_W-1 -: WAVE_W];
  assign state     = state_q;
  assign busy      = (state_q != IDLE);

  // Scaling pipeline: stage 1 captures the centred sample and the pre-update level.
  logic signed [WAVE_W:0]     s_q;
  logic [WAVE_W-1:0]          env_q;
  logic                       v1_q;
  logic signed [2*WAVE_W+1:0] prod;
  logic [WAVE_W-1:0]          wave_q;
  logic                       valid_q;
  logic                       unused_prod;

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q   <= '0;
      env_q <= '0;
      v1_q  <= 1'b0;
    end else begin
      v1_q <= sample_en;
      if (sample_en) begin
        s_q   <= $signed({1'b0, wave_in}) - $signed({2'b01, {(WAVE_W-1){1'b0}}});
        env_q <= env_level;
      end
    end
  end

  // Floor-shifting by WAVE_W then truncating is the same as slicing these bits.
  assign prod        = s_q * $signed({1'b0, env_q});
  assign unused_prod = ^{prod[2*WAVE_W+1:2*WAVE_W], prod[WAVE_W-1:0]};

  always_ff @(posedge clk) begin
    if (rst) begin
      wave_q  <= MID;
      valid_q <= 1'b0;
    end else begin
      valid_q <= v1_q;
      if (v1_q) wave_q <= prod[WAVE_W +: WAVE_W] + MID;
    end
  end

  assign wave_out  = wave_q;
  assign out_valid = valid_q;

endmodule
